// File: rtl/gray_counter_n_if.sv
// Counter control and status bundle for gray_counter_n.
// The master drives control into the counter; the slave side is the counter itself.
interface gray_counter_n_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] bin;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  count, bin, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, bin, tc, wrap
  );
endinterface

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray counter with load, wrap/saturate boundary mode,
// registered Gray and binary outputs, terminal-count and wrap-pulse flags.
module gray_counter_n #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input logic            clk,
  input logic            rst_n,
  gray_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] max_val = '1;
  localparam logic [WIDTH-1:0] one_val = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_bin  = bin_q;
    next_wrap = 1'b0;
    if (bus.load) begin
      next_bin = bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (bin_q != max_val) begin
          next_bin = bin_q + one_val;
        end else if (SATURATE == 0) begin
          next_bin  = '0;
          next_wrap = 1'b1;
        end
      end else begin
        if (bin_q != '0) begin
          next_bin = bin_q - one_val;
        end else if (SATURATE == 0) begin
          next_bin  = max_val;
          next_wrap = 1'b1;
        end
      end
    end
  end

  // Gray is encoded from next_bin and registered so count never glitches.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      bin_q   <= next_bin;
      count_q <= next_bin ^ (next_bin >> 1);
      wrap_q  <= next_wrap;
    end
  end

  assign bus.bin   = bin_q;
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = bus.up_dn ? (bin_q == max_val) : (bin_q == '0);

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: three instances cover wrap mode at
// widths 4 and 8 and saturate mode at width 4.
module tb_gray_counter_n;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gray_counter_n_if #(.WIDTH(4)) a_if ();
  gray_counter_n_if #(.WIDTH(8)) b_if ();
  gray_counter_n_if #(.WIDTH(4)) c_if ();

  gray_counter_n #(.WIDTH(4), .SATURATE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  gray_counter_n #(.WIDTH(8), .SATURATE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  gray_counter_n #(.WIDTH(4), .SATURATE(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] prev_count;
    logic [3:0] exp_bin;

    rst_n = 1'b0;
    a_if.en = 1'b1; a_if.up_dn = 1'b1; a_if.load = 1'b0; a_if.load_val = '0;
    b_if.en = 1'b0; b_if.up_dn = 1'b0; b_if.load = 1'b0; b_if.load_val = '0;
    c_if.en = 1'b0; c_if.up_dn = 1'b1; c_if.load = 1'b0; c_if.load_val = '0;

    // Reset held across edges with en high.
    step();
    step();
    check("rst_count", a_if.count, 0);
    check("rst_bin",   a_if.bin,   0);
    check("rst_wrap",  a_if.wrap,  0);
    check("rst_tc_up", a_if.tc,    0);
    check("rst_tc_dn", b_if.tc,    1);
    rst_n = 1'b1;

    // Full up-cycle, 20 edges, wrap mode.
    prev_count = a_if.count;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_bin = 4'(i % 16);
      check($sformatf("up_bin_%0d", i),   a_if.bin,   exp_bin);
      check($sformatf("up_count_%0d", i), a_if.count, gray4(exp_bin));
      check($sformatf("up_onebit_%0d", i), $countones(a_if.count ^ prev_count), 1);
      check($sformatf("up_tc_%0d", i),    a_if.tc,    (exp_bin == 4'd15) ? 1 : 0);
      check($sformatf("up_wrap_%0d", i),  a_if.wrap,  (exp_bin == 4'd0) ? 1 : 0);
      prev_count = a_if.count;
    end
    a_if.en = 1'b0;

    // Down/wrap at width 8: load 0, then step down.
    b_if.load_val = 8'd0; b_if.load = 1'b1;
    step();
    check("dn_load_count", b_if.count, 0);
    check("dn_load_tc",    b_if.tc,    1);
    b_if.load = 1'b0; b_if.en = 1'b1;
    step();
    check("dn_bin",   b_if.bin,   8'd255);
    check("dn_count", b_if.count, 8'h80);
    check("dn_wrap",  b_if.wrap,  1);
    b_if.en = 1'b0;
    step();
    check("dn_hold_bin",  b_if.bin,  8'd255);
    check("dn_wrap_off",  b_if.wrap, 0);

    // Saturate mode: load 14, then three up steps.
    c_if.load_val = 4'd14; c_if.load = 1'b1;
    step();
    check("sat_load_bin", c_if.bin, 14);
    c_if.load = 1'b0; c_if.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sat_bin_%0d", i),   c_if.bin,   15);
      check($sformatf("sat_count_%0d", i), c_if.count, 4'b1000);
      check($sformatf("sat_wrap_%0d", i),  c_if.wrap,  0);
      check($sformatf("sat_tc_%0d", i),    c_if.tc,    1);
    end
    c_if.en = 1'b0;

    // Load priority over en, then direction flips.
    a_if.load = 1'b1; a_if.en = 1'b1; a_if.up_dn = 1'b1; a_if.load_val = 4'd5;
    step();
    check("ld_bin",   a_if.bin,   5);
    check("ld_count", a_if.count, 4'b0111);
    check("ld_wrap",  a_if.wrap,  0);
    a_if.load = 1'b0; a_if.up_dn = 1'b0;
    step();
    check("flip_dn_bin",   a_if.bin,   4);
    check("flip_dn_count", a_if.count, 4'b0110);
    a_if.up_dn = 1'b1;
    step();
    check("flip_up_bin",   a_if.bin,   5);
    check("flip_up_count", a_if.count, 4'b0111);

    // Async reset mid-cycle with a wrap pending.
    a_if.load = 1'b1; a_if.load_val = 4'd15; a_if.en = 1'b0;
    step();
    a_if.load = 1'b0; a_if.en = 1'b1;
    check("pre_rst_bin", a_if.bin, 15);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bin",   a_if.bin,   0);
    check("arst_count", a_if.count, 0);
    check("arst_wrap",  a_if.wrap,  0);
    step();
    rst_n = 1'b1;
    a_if.en = 1'b0;
    step();
    check("post_rst_wrap", a_if.wrap, 0);
    check("post_rst_bin",  a_if.bin,  0);
    step();
    check("post_rst_wrap2", a_if.wrap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code counter, the successor to the fixed 8-bit free-running Gray counter. It adds configurable width, count enable, up/down direction, synchronous binary load, and a wrap or saturate boundary mode. It exposes both the Gray value and its binary equivalent, plus terminal-count and wrap indicators. It is used as a pointer or sequence generator wherever single-bit-change outputs must cross into other logic, e.g. FIFO pointers and encoder sequencing.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32
- SATURATE, 0, boundary mode: 0 = wrap around, 1 = hold at the boundary
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; one step per cycle while high
- up_dn  input  1  direction: 1 = count up, 0 = count down
- load  input  1  synchronous load strobe; priority over en
- load_val  input  WIDTH  binary value to load
- count  output  WIDTH  registered Gray-coded count
- bin  output  WIDTH  registered binary count, always equal to the Gray decode of count
- tc  output  1  terminal count: at the boundary for the current direction
- wrap  output  1  registered one-cycle pulse: the count wrapped on the previous edge

## Operation
- Internal state is the binary register bin_q. Both count and bin are flops, not decoded combinationally, so count is glitch-free.
- On each edge, compute next_bin, then load bin <= next_bin and count <= next_bin ^ (next_bin >> 1).
- Rules for next_bin, in priority order:
  - load = 1: next_bin = load_val. en and up_dn are ignored. wrap <= 0.
  - en = 1, up_dn = 1, bin_q < 2^WIDTH-1: next_bin = bin_q + 1.
  - en = 1, up_dn = 0, bin_q > 0: next_bin = bin_q - 1.
  - en = 1 at the boundary (up at max, or down at 0):
    - SATURATE = 0: next_bin wraps (max -> 0 or 0 -> max) and wrap <= 1.
    - SATURATE = 1: next_bin = bin_q and wrap <= 0.
  - en = 0: hold. wrap <= 0.
- All arithmetic is modulo 2^WIDTH. No carry-out port.
- tc is combinational from registered state and up_dn:
  - up_dn = 1: tc = (bin_q == 2^WIDTH-1)
  - up_dn = 0: tc = (bin_q == 0)
  - tc does not depend on en or load.
- Gray property: every transition caused by en changes exactly one bit of count. A hold changes zero bits. A load may change any number of bits.
- A direction change mid-sequence takes effect on the same edge. There is no pipeline or state machine beyond the counter register.

## Timing
- Reset (rst_n low, asynchronous, no clock needed):
  - count = 0, bin = 0, wrap = 0
  - tc = 1 if up_dn = 0, else 0
- Reset release is synchronous to the next rising edge. The first count step is on the first edge with rst_n high and en high.
- Latency:
  - en or load sampled at edge N; count and bin updated at edge N.
  - wrap is high for exactly the cycle following the wrapping edge.
- Reset asserted mid-count clears all outputs immediately and cancels any pending wrap pulse.
- Continuous en with SATURATE = 0 and up_dn = 1 gives period 2^WIDTH cycles, with one wrap pulse per period.

## Test plan
- Reset/enable (WIDTH = 4): hold rst_n = 0 with clk running, en = 1 -> count = 0000, bin = 0, wrap = 0. Release, en = 1, up_dn = 1 for 3 edges -> count 0001, 0011, 0010 and bin 1, 2, 3.
- Full up-cycle (WIDTH = 4, SATURATE = 0, en = 1, 20 edges):
  - count/bin reaches 1000/15 with tc = 1, then 0000/0 with wrap = 1 for one cycle.
  - Every step differs by exactly one bit.
- Down/wrap (WIDTH = 8, SATURATE = 0): load_val = 0, load = 1 -> count = 0, tc = 1 when up_dn = 0. Then en = 1, up_dn = 0 -> bin = 255, count = 10000000, wrap pulse.
- Saturate (WIDTH = 4, SATURATE = 1): load_val = 14, then 3 edges en = 1, up_dn = 1 -> bin 15, 15, 15, count = 1000, wrap never asserts, tc = 1.
- Load priority and direction flip (WIDTH = 4): load = 1, en = 1, load_val = 5 -> bin = 5, count = 0111. Then en = 1, up_dn = 0 -> bin = 4 (count 0110). Then up_dn = 1 -> bin = 5.
- Async reset mid-count: at bin = 15 with wrap pending, pull rst_n low mid-cycle -> outputs read 0 before the next edge, and no wrap pulse appears after release.
